// File: rtl/draw_playfield.sv
`default_nettype none
// ============================================================================
// Module   : draw_playfield
// Purpose  : Colour renderer for the game playfield and the next-piece
//            preview. Fetches one packed playfield row per raster line from
//            the game-area RAM, decodes per-cell colour codes through a fixed
//            palette and emits r/g/b plus dav three cycles after x/y.
// Options  : GRID_LINES_EN - when defined, empty in-field cells draw a dim
//            grid on their first pixel column and first line.
// Revision : 1.0 - initial colour renderer
// ============================================================================
module draw_playfield #(
  parameter int          COLS       = 12,
  parameter int          ROWS       = 20,
  parameter int          CELL_BITS  = 3,
  parameter int          CELL_PX    = 21,
  parameter int          ORG_X      = 272,
  parameter int          ORG_Y      = 129,
  parameter int          PREV_X     = 600,
  parameter int          PREV_Y     = 272,
  parameter logic [3:0]  STATE_LOGO = 4'h0
) (
  input  logic                          vga_clk,
  input  logic                          rst,
  input  logic [10:0]                   x,
  input  logic [9:0]                    y,
  input  logic [3:0]                    game_state,
  output logic [$clog2(ROWS)-1:0]       row_addr,
  input  logic [COLS*CELL_BITS-1:0]     row_data,
  input  logic [7:0]                    next_mask,
  input  logic [CELL_BITS-1:0]          next_color,
  output logic [1:0]                    r,
  output logic [1:0]                    g,
  output logic [1:0]                    b,
  output logic                          dav
);

  // Counter widths: row/col must be able to hold ROWS/COLS as an end marker.
  localparam int c_aw = $clog2(ROWS);
  localparam int c_rw = $clog2(ROWS + 1);
  localparam int c_cw = $clog2(COLS + 1);
  localparam int c_sw = $clog2(CELL_PX);

  localparam logic [10:0]     c_org_x     = 11'(ORG_X);
  localparam logic [10:0]     c_field_end = 11'(ORG_X + COLS * CELL_PX);
  localparam logic [9:0]      c_org_y     = 10'(ORG_Y);
  localparam logic [c_sw-1:0] c_sub_last  = c_sw'(CELL_PX - 1);
  localparam logic [c_rw-1:0] c_rows      = c_rw'(ROWS);
  localparam logic [c_cw-1:0] c_cols      = c_cw'(COLS);

  // Fixed palette; code 0 never reaches the outputs as a filled cell.
  function automatic logic [5:0] palette(input logic [CELL_BITS-1:0] code);
    logic [31:0] v;
    v = 32'(code);
    case (v)
      32'd0:   palette = 6'b00_00_00;
      32'd1:   palette = 6'b00_11_11;
      32'd2:   palette = 6'b00_00_11;
      32'd3:   palette = 6'b11_10_00;
      32'd4:   palette = 6'b11_11_00;
      32'd5:   palette = 6'b00_11_00;
      32'd6:   palette = 6'b10_00_11;
      32'd7:   palette = 6'b11_00_00;
      default: palette = 6'b11_11_11;
    endcase
  endfunction

  // Line-rate row state
  logic [c_rw-1:0] r_row;
  logic [c_sw-1:0] r_row_sub;
  logic            r_row_sync;
  logic [c_rw-1:0] w_row_inc;

  // Stage 1
  logic [c_cw-1:0] r_col;
  logic [c_sw-1:0] r_col_sub;
  logic            r_in_field_s1;
  logic            r_prev_in_s1;
  logic [1:0]      r_prev_col_s1;
  logic            r_prev_row_s1;

  // Stage 1 combinational preview decode
  logic            w_prev_in_x;
  logic            w_prev_in_y;
  logic [1:0]      w_prev_col;
  logic            w_prev_row;

  // Stage 2
  logic [CELL_BITS-1:0] w_cell;
  logic [CELL_BITS-1:0] r_cell_s2;
  logic                 r_prev_hit_s2;
  logic [CELL_BITS-1:0] r_prev_color_s2;
`ifdef GRID_LINES_EN
  logic                 r_grid_s2;
`endif

  assign w_row_inc = r_row + 1'b1;

  // Row tracking: re-armed on the ORG_Y line, advanced once per line at x == 0
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_row      <= '0;
      r_row_sub  <= '0;
      r_row_sync <= 1'b0;
      row_addr   <= '0;
    end else if (x == 11'd0) begin
      if (y == c_org_y) begin
        r_row      <= '0;
        r_row_sub  <= '0;
        r_row_sync <= 1'b1;
        row_addr   <= '0;
      end else if (r_row_sync) begin
        if (r_row_sub == c_sub_last) begin
          r_row_sub <= '0;
          r_row     <= w_row_inc;
          if (w_row_inc == c_rows) begin
            // Past the last row: stop drawing, keep the RAM address in range.
            r_row_sync <= 1'b0;
          end else begin
            row_addr <= w_row_inc[c_aw-1:0];
          end
        end else begin
          r_row_sub <= r_row_sub + 1'b1;
        end
      end
    end
  end

  // Preview cell decode from constant-range compares on the raster position
  always_comb begin
    w_prev_in_x = 1'b0;
    w_prev_col  = '0;
    w_prev_in_y = 1'b0;
    w_prev_row  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (x >= 11'(PREV_X + i * CELL_PX) && x < 11'(PREV_X + (i + 1) * CELL_PX)) begin
        w_prev_in_x = 1'b1;
        w_prev_col  = 2'(i);
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (y >= 10'(PREV_Y + j * CELL_PX) && y < 10'(PREV_Y + (j + 1) * CELL_PX)) begin
        w_prev_in_y = 1'b1;
        w_prev_row  = (j != 0);
      end
    end
  end

  // Stage 1: column counters, field window and preview position
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_col         <= '0;
      r_col_sub     <= '0;
      r_in_field_s1 <= 1'b0;
      r_prev_in_s1  <= 1'b0;
      r_prev_col_s1 <= '0;
      r_prev_row_s1 <= 1'b0;
    end else begin
      if (x == c_org_x) begin
        r_col     <= '0;
        r_col_sub <= '0;
      end else if (r_col_sub == c_sub_last) begin
        r_col_sub <= '0;
        if (r_col != c_cols) begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        r_col_sub <= r_col_sub + 1'b1;
      end
      r_in_field_s1 <= r_row_sync && (x >= c_org_x) && (x < c_field_end);
      r_prev_in_s1  <= w_prev_in_x && w_prev_in_y;
      r_prev_col_s1 <= w_prev_col;
      r_prev_row_s1 <= w_prev_row;
    end
  end

  // Cell select: explicit mux so out-of-range columns read as empty
  always_comb begin
    w_cell = '0;
    for (int c = 0; c < COLS; c++) begin
      if (r_col == c_cw'(c)) begin
        w_cell = row_data[c*CELL_BITS +: CELL_BITS];
      end
    end
  end

  // Stage 2: cell fetch and preview hit test
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_cell_s2       <= '0;
      r_prev_hit_s2   <= 1'b0;
      r_prev_color_s2 <= '0;
`ifdef GRID_LINES_EN
      r_grid_s2       <= 1'b0;
`endif
    end else begin
      r_cell_s2       <= r_in_field_s1 ? w_cell : '0;
      r_prev_hit_s2   <= r_prev_in_s1 && (game_state != STATE_LOGO) &&
                         next_mask[{r_prev_row_s1, r_prev_col_s1}];
      r_prev_color_s2 <= next_color;
`ifdef GRID_LINES_EN
      r_grid_s2       <= r_in_field_s1 && ((r_col_sub == '0) || (r_row_sub == '0));
`endif
    end
  end

  // Stage 3: priority select and palette lookup into the output registers
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      {r, g, b} <= 6'b0;
      dav       <= 1'b0;
    end else if (r_cell_s2 != '0) begin
      {r, g, b} <= palette(r_cell_s2);
      dav       <= 1'b1;
    end else if (r_prev_hit_s2) begin
      {r, g, b} <= palette(r_prev_color_s2);
      dav       <= 1'b1;
`ifdef GRID_LINES_EN
    end else if (r_grid_s2) begin
      {r, g, b} <= 6'b01_01_01;
      dav       <= 1'b1;
`endif
    end else begin
      {r, g, b} <= 6'b0;
      dav       <= 1'b0;
    end
  end

endmodule
`default_nettype wire
